mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv_bus_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arb_prio.sv | 25 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_bus_pkg.sv
// rtl/rv_bus_pkg.sv - shared widths and types for the instruction/data memory arbiter
package rv_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DR,
        OWN_DW
    } owner_e;

    typedef enum logic {
        IDLE,
        RESP
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM command bundle shared by the arbiter and its users
interface mem_arbiter_if;
    import rv_bus_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dr_req;
    logic [ADDR_W-1:0] dr_addr;
    logic              dr_gnt;
    logic              dr_rvalid;
    logic [DATA_W-1:0] dr_rdata;

    logic              dw_req;
    logic [ADDR_W-1:0] dw_addr;
    logic [DATA_W-1:0] dw_data;
    logic [3:0]        dw_strb;
    logic              dw_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_strb;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, dr_req, dr_addr,
        input  dw_req, dw_addr, dw_data, dw_strb, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dr_gnt, dr_rvalid, dr_rdata, dw_gnt,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_strb, stall
    );

    modport master (
        output if_req, if_addr, dr_req, dr_addr,
        output dw_req, dw_addr, dw_data, dw_strb, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dr_gnt, dr_rvalid, dr_rdata, dw_gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_strb, stall
    );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - combinational winner select: write > read > fetch unless fetch is starved
module mem_arb_prio
    import rv_bus_pkg::*;
(
    input  logic   if_req,
    input  logic   dr_req,
    input  logic   dw_req,
    input  logic   starve,
    output owner_e winner
);

    always_comb begin
        winner = OWN_NONE;
        if (if_req && starve) begin
            winner = OWN_IF;
        end else if (dw_req) begin
            winner = OWN_DW;
        end else if (dr_req) begin
            winner = OWN_DR;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester arbiter in front of a single-port synchronous RAM
module mem_arbiter
    import rv_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            winner;
    logic [1:0]        starve_q, starve_d;

    logic              if_gnt, dr_gnt, dw_gnt;
    logic              if_rvalid, dr_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_strb;
    logic              unused_addr_lsbs;

    mem_arb_prio u_prio (
        .if_req (bus.if_req),
        .dr_req (bus.dr_req),
        .dw_req (bus.dw_req),
        .starve (starve_q == STARVE_MAX),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        if_gnt    = 1'b0;
        dr_gnt    = 1'b0;
        dw_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dr_rvalid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;

        case (state_q)
            // Grants are combinational, so they are also held off while reset is asserted.
            IDLE: if (rst_n) begin
                case (winner)
                    OWN_DW: begin
                        dw_gnt    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = {bus.dw_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata = bus.dw_data;
                        mem_strb  = bus.dw_strb;
                    end
                    OWN_DR: begin
                        dr_gnt   = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = {bus.dr_addr[ADDR_W-1:2], 2'b00};
                        owner_d  = OWN_DR;
                        state_d  = RESP;
                    end
                    OWN_IF: begin
                        if_gnt   = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = {bus.if_addr[ADDR_W-1:2], 2'b00};
                        owner_d  = OWN_IF;
                        state_d  = RESP;
                    end
                    default: ;
                endcase
            end
            RESP: begin
                if_rvalid = (owner_q == OWN_IF);
                dr_rvalid = (owner_q == OWN_DR);
                owner_d   = OWN_NONE;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!bus.if_req || if_gnt) begin
            starve_d = '0;
        end else if ((dw_gnt || dr_gnt) && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 2'd1;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dr_gnt    = dr_gnt;
    assign bus.dw_gnt    = dw_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.dr_rvalid = dr_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    assign bus.dr_rdata  = dr_rvalid ? bus.mem_rdata : '0;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_strb  = mem_strb;
    assign bus.stall     = (bus.if_req & ~if_rvalid) | (bus.dr_req & ~dr_rvalid) | (bus.dw_req & ~dw_gnt);

    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.dr_addr[1:0], bus.dw_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter with an external RAM model
`timescale 1ns/1ps
module tb_mem_arbiter;
    import rv_bus_pkg::*;

    localparam int STARVE = 3;
    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_IF   = 2'd1;
    localparam logic [1:0] C_DR   = 2'd2;
    localparam logic [1:0] C_DW   = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ram_load = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)  return 32'h00500093;
        if (i == 32) return 32'h11223344;
        return (32'h9E3779B9 * i) ^ 32'hC3A55A3C;
    endfunction

    // RAM seen by the DUT
    logic [31:0] ram [0:255];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_strb[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                ram_q <= ram[bus.mem_addr[9:2]];
            end
        end
    end
    assign bus.mem_rdata = ram_q;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q[$];
    logic [1:0]  gnt_log[$];
    bit          mon_en = 1'b0;
    logic        resp_due;
    logic [1:0]  due_port;
    int          starve_cnt;
    logic [31:0] last_if_rdata, last_dr_rdata;

    logic [1:0]  m_exp;
    logic [2:0]  m_act;
    logic        m_if_rv, m_dr_rv, m_stall;
    logic [31:0] m_addr, m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < gnt_log.size()) return {30'd0, gnt_log[i]};
        return 32'hFFFF_FFFF;
    endfunction

    // Monitor: predicts the winner from the pending requests and checks every response
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            m_exp = C_NONE;
            if (!resp_due) begin
                if (bus.if_req && starve_cnt >= STARVE) m_exp = C_IF;
                else if (bus.dw_req)                    m_exp = C_DW;
                else if (bus.dr_req)                    m_exp = C_DR;
                else if (bus.if_req)                    m_exp = C_IF;
            end
            case ({bus.dw_gnt, bus.dr_gnt, bus.if_gnt})
                3'b000:  m_act = 3'd0;
                3'b001:  m_act = 3'd1;
                3'b010:  m_act = 3'd2;
                3'b100:  m_act = 3'd3;
                default: m_act = 3'd4;
            endcase
            chk("grant", {29'd0, m_act}, {30'd0, m_exp});
            chk("mem_en", {31'd0, bus.mem_en}, {31'd0, m_exp != C_NONE});

            if (m_exp == C_DW) begin
                chk("wr_we", {31'd0, bus.mem_we}, 32'd1);
                chk("wr_addr", bus.mem_addr, {bus.dw_addr[31:2], 2'b00});
                chk("wr_data", bus.mem_wdata, bus.dw_data);
                chk("wr_strb", {28'd0, bus.mem_strb}, {28'd0, bus.dw_strb});
                for (int b = 0; b < 4; b++)
                    if (bus.dw_strb[b]) ref_mem[bus.dw_addr[9:2]][8*b +: 8] = bus.dw_data[8*b +: 8];
                gnt_log.push_back(C_DW);
            end else if (m_exp != C_NONE) begin
                m_addr = (m_exp == C_DR) ? bus.dr_addr : bus.if_addr;
                chk("rd_we", {31'd0, bus.mem_we}, 32'd0);
                chk("rd_strb", {28'd0, bus.mem_strb}, 32'd0);
                chk("rd_addr", bus.mem_addr, {m_addr[31:2], 2'b00});
                exp_q.push_back(ref_mem[m_addr[9:2]]);
                gnt_log.push_back(m_exp);
            end

            m_if_rv = resp_due && due_port == C_IF;
            m_dr_rv = resp_due && due_port == C_DR;
            chk("if_rvalid", {31'd0, bus.if_rvalid}, {31'd0, m_if_rv});
            chk("dr_rvalid", {31'd0, bus.dr_rvalid}, {31'd0, m_dr_rv});
            if (resp_due) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_queue: got empty queue expected pending read at %0t", $time);
                end else begin
                    m_data = exp_q.pop_front();
                    if (m_if_rv) chk("if_rdata", bus.if_rdata, m_data);
                    else         chk("dr_rdata", bus.dr_rdata, m_data);
                end
            end
            if (!m_if_rv) chk("if_rdata_idle", bus.if_rdata, 32'd0);
            if (!m_dr_rv) chk("dr_rdata_idle", bus.dr_rdata, 32'd0);
            if (bus.if_rvalid) last_if_rdata = bus.if_rdata;
            if (bus.dr_rvalid) last_dr_rdata = bus.dr_rdata;

            m_stall = (bus.if_req & ~m_if_rv) | (bus.dr_req & ~m_dr_rv) | (bus.dw_req & (m_exp != C_DW));
            chk("stall", {31'd0, bus.stall}, {31'd0, m_stall});

            resp_due = (m_exp == C_IF) || (m_exp == C_DR);
            due_port = m_exp;
            if (!bus.if_req || m_exp == C_IF) starve_cnt = 0;
            else if ((m_exp == C_DW || m_exp == C_DR) && starve_cnt < STARVE) starve_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input logic [1:0] which);
        int t = 0;
        forever begin
            @(negedge clk);
            if ((which == C_IF && bus.if_gnt) || (which == C_DR && bus.dr_gnt) || (which == C_DW && bus.dw_gnt)) break;
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL gnt_timeout: port %0d got no grant expected one within 200 cycles", which);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dw_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.dw_addr = a;
        bus.dw_data = d;
        bus.dw_strb = s;
        bus.dw_req  = 1'b1;
        wait_gnt(C_DW);
        bus.dw_req  = 1'b0;
    endtask

    task automatic dr_txn(input logic [31:0] a);
        bus.dr_addr = a;
        bus.dr_req  = 1'b1;
        wait_gnt(C_DR);
        bus.dr_req  = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a);
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        wait_gnt(C_IF);
        bus.if_req  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
    endfunction

    task automatic reset_model();
        resp_due   = 1'b0;
        due_port   = C_NONE;
        starve_cnt = 0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dr_req = 1'b0; bus.dr_addr = '0;
        bus.dw_req = 1'b0; bus.dw_addr = '0; bus.dw_data = '0; bus.dw_strb = '0;
        last_if_rdata = '0;
        last_dr_rdata = '0;
        reset_model();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        ram_load = 1'b1;
        @(posedge clk); #1;
        ram_load = 1'b0;
        bus.if_req = 1'b1; bus.dr_req = 1'b1; bus.dw_req = 1'b1;
        @(negedge clk);
        chk("rst_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
        chk("rst_dr_gnt", {31'd0, bus.dr_gnt}, 32'd0);
        chk("rst_dw_gnt", {31'd0, bus.dw_gnt}, 32'd0);
        chk("rst_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        chk("rst_dr_rvalid", {31'd0, bus.dr_rvalid}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_dr_rdata", bus.dr_rdata, 32'd0);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.dr_req = 1'b0; bus.dw_req = 1'b0;
        @(negedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        if_txn(32'h10);
        idle(2);
        chk("fetch_data", last_if_rdata, 32'h00500093);

        gnt_log.delete();
        fork
            dw_txn(32'h40, 32'hDEADBEEF, 4'hF);
            dr_txn(32'h40);
        join
        idle(2);
        chk("wr_rd_order0", log_at(0), {30'd0, C_DW});
        chk("wr_rd_order1", log_at(1), {30'd0, C_DR});
        chk("wr_rd_data", last_dr_rdata, 32'hDEADBEEF);

        dw_txn(32'h80, 32'h0000AA00, 4'h2);
        dr_txn(32'h80);
        idle(2);
        chk("strobe_readback", last_dr_rdata, 32'h1122AA44);

        gnt_log.delete();
        fork
            dw_txn(rand_addr(), $urandom, 4'($urandom_range(1, 15)));
            dr_txn(rand_addr());
            if_txn(rand_addr());
        join
        idle(2);
        chk("all3_count", gnt_log.size(), 32'd3);
        chk("all3_first", log_at(0), {30'd0, C_DW});
        chk("all3_second", log_at(1), {30'd0, C_DR});
        chk("all3_third", log_at(2), {30'd0, C_IF});

        gnt_log.delete();
        fork
            repeat (5) dw_txn(rand_addr(), $urandom, 4'hF);
            if_txn(rand_addr());
        join
        idle(2);
        chk("starve_count", gnt_log.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("starve_seq", log_at(i), (i == 3) ? {30'd0, C_IF} : {30'd0, C_DW});

        fork
            repeat (15) begin idle($urandom_range(0, 3)); dw_txn(rand_addr(), $urandom, 4'($urandom_range(1, 15))); end
            repeat (15) begin idle($urandom_range(0, 3)); dr_txn(rand_addr()); end
            repeat (15) begin idle($urandom_range(0, 3)); if_txn(rand_addr()); end
        join
        idle(3);
        chk("resp_queue_drained", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        bus.if_addr = 32'h10;
        bus.if_req  = 1'b1;
        @(negedge clk);
        chk("rst_resp_gnt", {31'd0, bus.if_gnt}, 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        chk("abort_if_rdata", bus.if_rdata, 32'd0);
        chk("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("abort_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_rvalid", {31'd0, bus.if_rvalid | bus.dr_rvalid}, 32'd0);
        #1;
        reset_model();
        last_if_rdata = '0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        if_txn(32'h10);
        idle(2);
        chk("refetch_data", last_if_rdata, ref_mem[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
